crc_block_sequencer: RTL and testbench
======================================

CRC_BLOCK_SEQUENCER -- requirements
Module: crc_block_sequencer

Interface
REQ-001 Parameter NBYTES, default 32: data bytes per mempak block fed to the CRC engine.
REQ-002 Parameter BYTE_CYCLES, default 36: cycles the engine is allowed per byte after crc_start, counted from the cycle after crc_start; range 33..63.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 tx_req  input  1  write path requests CRC generation of a block; level, held until tx_done.
REQ-006 rx_req  input  1  read path requests CRC check of a block; level, held until rx_done.
REQ-007 rx_expected  input  8  CRC byte received from the pak; sampled in state FINAL.
REQ-008 tx_gnt / rx_gnt  output  1 each  grant; high from CLEAR through DONE for the owner only.
REQ-009 byte_addr  output  5  index of the requested byte in the granted requester's buffer.
REQ-010 byte_rd  output  1  one-cycle read strobe; byte_data is valid exactly one cycle later.
REQ-011 byte_data  input  8  byte returned by the granted requester's buffer.
REQ-012 crc_clear  output  1  one-cycle pulse, ORed into the engine's reset at top level.
REQ-013 crc_data  output  8  byte presented to the engine; held stable from crc_start until the next FETCH.
REQ-014 crc_start  output  1  one-cycle pulse into the engine's data_ready.
REQ-015 crc_result  input  8  engine output register.
REQ-016 crc_out  output  8  final CRC, registered; valid while tx_done or rx_done is high and held until the next CLEAR.
REQ-017 tx_done / rx_done  output  1 each  one-cycle completion pulse for the owner.
REQ-018 crc_match  output  1  registered (crc_out == rx_expected); meaningful with rx_done; forced 0 on tx completion.

Function
REQ-019 States: IDLE, CLEAR, FETCH, WAIT_DATA, FEED, WAIT_ENG, FINAL, DONE; all outputs are registered.
REQ-020 IDLE: if any request is pending, the sequencer latches the owner, asserts its grant and goes to CLEAR; otherwise it stays in IDLE.
REQ-021 Arbitration is round-robin: when both requests are high in IDLE, the one not granted last wins; after reset, tx wins the first tie.
REQ-022 CLEAR: crc_clear=1 for one cycle, byte counter=0, then FETCH.
REQ-023 FETCH: byte_rd=1, byte_addr=counter[4:0], then WAIT_DATA; when counter==NBYTES, no byte_rd is issued, crc_data=8'h00 (pad byte) and the next state is FEED.
REQ-024 WAIT_DATA: crc_data<=byte_data, then FEED.
REQ-025 FEED: crc_start=1 for one cycle, wait counter loaded with BYTE_CYCLES, then WAIT_ENG.
REQ-026 WAIT_ENG: wait counter decrements each cycle; at 0, byte counter increments and the next state is FETCH if the new count <= NBYTES, else FINAL.
REQ-027 Exactly NBYTES+1 crc_start pulses occur per block (NBYTES data bytes plus one 0x00 pad); the byte counter is 6 bits and never wraps.
REQ-028 FINAL: crc_out<=crc_result, crc_match<=(owner==rx)&&(crc_result==rx_expected), then DONE.
REQ-029 DONE: owner's done pulses for one cycle, grant drops at the end of the cycle, next state IDLE; a request still high in IDLE is arbitrated as new.
REQ-030 Latency with NBYTES=32, BYTE_CYCLES=36 is fixed: grant at cycle 0, done at cycle 1+32*(3+37)+(2+37)+2 = 1322.
REQ-031 A requester deasserting its request mid-block does not abort the block; the block completes and the done pulse is still issued.
REQ-032 A new request arriving mid-block is held pending and is served after DONE.

Reset
REQ-033 On reset: state=IDLE; all counters=0; grants, byte_rd, crc_clear, crc_start, done pulses and crc_match=0; crc_out, crc_data and byte_addr=8'h00/5'h00; the round-robin pointer favours tx.
REQ-034 Reset asserted mid-block abandons the block with no done pulse; after release the sequencer waits in IDLE and re-arbitrates.

Verification
REQ-035 tx_req only, buffer all 8'h00 -> 33 crc_start pulses, tx_done at cycle 1322, crc_out=8'h00, crc_match=0.
REQ-036 rx_req, buffer bytes 0x00..0x1F, rx_expected equal to the CRC from the behavioural model -> rx_done with crc_match=1; repeat with rx_expected XOR 8'h01 -> crc_match=0.
REQ-037 tx_req and rx_req rise in the same cycle after reset -> tx served first, then rx; grants are never high together; second block is also tx/rx alternating if both are held.
REQ-038 byte_rd/byte_addr trace -> addresses 0..31 in order, one read per data byte, no read for the pad byte.
REQ-039 Reset pulsed in WAIT_ENG of byte 10 -> outputs at reset values, no done pulse; next request completes normally with the correct CRC.
REQ-040 tx_req dropped at byte 5 -> block completes, tx_done pulses, no extra grant issued.

Source files
------------

// File: rtl/crc_block_sequencer_if.sv
// ---------------------------------------------------------------------------
// crc_block_sequencer_if
//
// Bundles the signals between the CRC block sequencer and its environment.
// The environment is the two requesters (write path and read path), their
// block buffers, and the CRC engine.
//
//   master : the sequencer side (drives grants, buffer reads, engine control,
//            result and completion pulses)
//   slave  : the environment side (drives requests, buffer data, expected
//            CRC and the engine result)
//
// Signals:
//   tx_req, rx_req     block requests from the write / read path (levels)
//   rx_expected[7:0]   CRC byte received from the pak, compared at the end
//   tx_gnt, rx_gnt     grant to the current owner
//   byte_addr[4:0]     buffer index of the byte being read
//   byte_rd            one-cycle read strobe, data valid one cycle later
//   byte_data[7:0]     byte returned by the granted requester's buffer
//   crc_clear          one-cycle engine clear pulse
//   crc_data[7:0]      byte presented to the engine
//   crc_start          one-cycle engine data_ready pulse
//   crc_result[7:0]    engine output register
//   crc_out[7:0]       final CRC of the block
//   tx_done, rx_done   one-cycle completion pulse for the owner
//   crc_match          read-path check result, valid with rx_done
// ---------------------------------------------------------------------------
interface crc_block_sequencer_if;
    logic       tx_req;
    logic       rx_req;
    logic [7:0] rx_expected;
    logic       tx_gnt;
    logic       rx_gnt;
    logic [4:0] byte_addr;
    logic       byte_rd;
    logic [7:0] byte_data;
    logic       crc_clear;
    logic [7:0] crc_data;
    logic       crc_start;
    logic [7:0] crc_result;
    logic [7:0] crc_out;
    logic       tx_done;
    logic       rx_done;
    logic       crc_match;

    modport master (
        input  tx_req, rx_req, rx_expected, byte_data, crc_result,
        output tx_gnt, rx_gnt, byte_addr, byte_rd, crc_clear, crc_data,
               crc_start, crc_out, tx_done, rx_done, crc_match
    );

    modport slave (
        output tx_req, rx_req, rx_expected, byte_data, crc_result,
        input  tx_gnt, rx_gnt, byte_addr, byte_rd, crc_clear, crc_data,
               crc_start, crc_out, tx_done, rx_done, crc_match
    );
endinterface

// File: rtl/crc_block_sequencer.sv
// ---------------------------------------------------------------------------
// crc_block_sequencer
//
// This module arbitrates between the write path (tx) and the read path (rx) of
// a mempak controller. Each side requests a CRC over one block. For each block
// the module:
//   1. clears the CRC engine,
//   2. reads NBYTES bytes from the owner's buffer in address order,
//   3. feeds each byte to the engine, then a trailing 0x00 pad byte,
//   4. gives the engine BYTE_CYCLES+1 cycles to absorb each byte,
//   5. registers the final CRC and, for rx, compares it with rx_expected.
//
// Arbitration is round-robin. If both sides request in the same cycle, the
// side that was not served last wins. After reset, tx wins the first tie.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high; abandons any block in progress
//   bus    crc_block_sequencer_if.master (see the interface file)
//
// Parameters:
//   NBYTES       data bytes per block (<= 32, addressed by byte_addr[4:0])
//   BYTE_CYCLES  engine cycles allowed per byte, 33..63
// ---------------------------------------------------------------------------
module crc_block_sequencer #(
    parameter int NBYTES      = 32,
    parameter int BYTE_CYCLES = 36
) (
    input  logic                          clk,
    input  logic                          reset,
    crc_block_sequencer_if.master         bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        WAIT_DATA,
        FEED,
        WAIT_ENG,
        FINAL,
        DONE
    } state_t;

    localparam logic [5:0] LAST_BYTE = 6'(NBYTES);
    localparam logic [5:0] WAIT_LOAD = 6'(BYTE_CYCLES);

    state_t     state;
    logic [5:0] byte_cnt;
    logic [5:0] wait_cnt;
    logic       owner_rx;
    logic       last_rx;
    logic       pick_rx;
    logic [5:0] next_cnt;

    // last_rx = 1 means rx was served most recently, so tx wins a tie.
    assign pick_rx  = bus.rx_req && (!bus.tx_req || !last_rx);
    assign next_cnt = byte_cnt + 6'd1;

    // Single sequencing process. Every output is a register that takes the
    // value belonging to the state being entered, so each pulse lines up
    // with its state. byte_rd is raised when FETCH is entered. The pad
    // step (byte_cnt == NBYTES) enters FETCH with no read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            byte_cnt      <= 6'd0;
            wait_cnt      <= 6'd0;
            owner_rx      <= 1'b0;
            last_rx       <= 1'b1;
            bus.tx_gnt    <= 1'b0;
            bus.rx_gnt    <= 1'b0;
            bus.byte_addr <= 5'h00;
            bus.byte_rd   <= 1'b0;
            bus.crc_clear <= 1'b0;
            bus.crc_data  <= 8'h00;
            bus.crc_start <= 1'b0;
            bus.crc_out   <= 8'h00;
            bus.tx_done   <= 1'b0;
            bus.rx_done   <= 1'b0;
            bus.crc_match <= 1'b0;
        end else begin
            bus.byte_rd   <= 1'b0;
            bus.crc_clear <= 1'b0;
            bus.crc_start <= 1'b0;
            bus.tx_done   <= 1'b0;
            bus.rx_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.tx_req || bus.rx_req) begin
                        owner_rx      <= pick_rx;
                        last_rx       <= pick_rx;
                        bus.tx_gnt    <= !pick_rx;
                        bus.rx_gnt    <= pick_rx;
                        bus.crc_clear <= 1'b1;
                        state         <= CLEAR;
                    end
                end

                CLEAR: begin
                    byte_cnt      <= 6'd0;
                    bus.byte_rd   <= (LAST_BYTE != 6'd0);
                    bus.byte_addr <= 5'h00;
                    state         <= FETCH;
                end

                FETCH: begin
                    if (byte_cnt == LAST_BYTE) begin
                        bus.crc_data  <= 8'h00;
                        bus.crc_start <= 1'b1;
                        state         <= FEED;
                    end else begin
                        state <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    bus.crc_data  <= bus.byte_data;
                    bus.crc_start <= 1'b1;
                    state         <= FEED;
                end

                FEED: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT_ENG;
                end

                // The wait counter runs from BYTE_CYCLES down to 0. That gives
                // BYTE_CYCLES+1 cycles here before the next byte or FINAL.
                WAIT_ENG: begin
                    if (wait_cnt == 6'd0) begin
                        byte_cnt <= next_cnt;
                        if (next_cnt <= LAST_BYTE) begin
                            bus.byte_rd <= (next_cnt != LAST_BYTE);
                            if (next_cnt != LAST_BYTE) begin
                                bus.byte_addr <= next_cnt[4:0];
                            end
                            state <= FETCH;
                        end else begin
                            state <= FINAL;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 6'd1;
                    end
                end

                // A tx block never reports a match.
                FINAL: begin
                    bus.crc_out   <= bus.crc_result;
                    bus.crc_match <= owner_rx && (bus.crc_result == bus.rx_expected);
                    bus.tx_done   <= !owner_rx;
                    bus.rx_done   <= owner_rx;
                    state         <= DONE;
                end

                DONE: begin
                    bus.tx_gnt <= 1'b0;
                    bus.rx_gnt <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_crc_block_sequencer
//
// Self-checking bench for crc_block_sequencer.
//
// Bench models:
//   - Two block buffers with one-cycle read latency.
//   - A bit-serial CRC-8 engine (polynomial 0x85) driven by crc_clear and
//     crc_start.
//   - A reference model that computes the expected CRC of a whole block
//     directly, including the 0x00 pad byte.
//
// Checking flow:
//   - The stimulus process predicts which requester is served next, using
//     the round-robin rule.
//   - It pushes the expected owner, CRC and match bit into a queue.
//   - A monitor on the falling edge traces reads and engine feeds, and
//     pops and checks one queue entry on every done pulse.
//
// Cycle numbering: cycle 0 is the IDLE cycle that accepts the request. The
// grant register is visible from cycle 1 (CLEAR), and done is visible at
// cycle LATENCY.
// ---------------------------------------------------------------------------
module tb_crc_block_sequencer;

    localparam int NBYTES      = 32;
    localparam int BYTE_CYCLES = 36;
    localparam int LATENCY     = 1 + NBYTES * (3 + BYTE_CYCLES + 1)
                                   + (2 + BYTE_CYCLES + 1) + 2;

    typedef struct {
        bit         is_rx;
        logic [7:0] crc;
        bit         match;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    crc_block_sequencer_if bus ();

    crc_block_sequencer #(
        .NBYTES      (NBYTES),
        .BYTE_CYCLES (BYTE_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    logic [7:0] tx_buf [NBYTES];
    logic [7:0] rx_buf [NBYTES];
    bit         last_rx_m = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Records one comparison and prints a FAIL line when it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Reference CRC over a whole block, with the 0x00 pad byte appended.
    function automatic logic [7:0] refCrc(input bit is_rx);
        int c = 0;
        for (int i = 0; i <= NBYTES; i++) begin
            int b = 0;
            if (i < NBYTES) b = is_rx ? int'(rx_buf[i]) : int'(tx_buf[i]);
            for (int k = 7; k >= 0; k--) begin
                c = (c << 1) | ((b >> k) & 1);
                if ((c & 'h100) != 0) c = c ^ 'h185;
            end
        end
        return 8'(c);
    endfunction

    // Buffer model: a strobe seen in one cycle returns data in the next.
    // Every other cycle carries garbage, so early or late sampling shows up.
    logic [7:0] byte_q     = 8'h00;
    bit         rd_pending = 1'b0;
    logic [4:0] rd_addr    = 5'h00;
    bit         rd_rx      = 1'b0;
    assign bus.byte_data = byte_q;

    always @(negedge clk) begin
        if (rd_pending) byte_q = rd_rx ? rx_buf[rd_addr] : tx_buf[rd_addr];
        else            byte_q = 8'($urandom);
        rd_pending = bus.byte_rd;
        rd_addr    = bus.byte_addr;
        rd_rx      = bus.rx_gnt;
    end

    // Bit-serial CRC engine: absorbs one bit per cycle after crc_start.
    logic [7:0] eng_crc;
    logic [7:0] eng_sh;
    logic [3:0] eng_bits;
    assign bus.crc_result = eng_crc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_crc  <= 8'h00;
            eng_sh   <= 8'h00;
            eng_bits <= 4'd0;
        end else if (bus.crc_clear) begin
            eng_crc  <= 8'h00;
            eng_bits <= 4'd0;
        end else if (bus.crc_start) begin
            eng_sh   <= bus.crc_data;
            eng_bits <= 4'd8;
        end else if (eng_bits != 4'd0) begin
            eng_crc  <= {eng_crc[6:0], eng_sh[7]} ^ (eng_crc[7] ? 8'h85 : 8'h00);
            eng_sh   <= {eng_sh[6:0], 1'b0};
            eng_bits <= eng_bits - 4'd1;
        end
    end

    // Monitor: traces each block and checks it against the scoreboard.
    bit prev_gnt    = 1'b0;
    bit mon_rx      = 1'b0;
    int grant_cyc   = 0;
    int reads       = 0;
    int starts      = 0;
    int grant_count = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_gnt = 1'b0;
            reads    = 0;
            starts   = 0;
        end else begin
            if (bus.tx_gnt && bus.rx_gnt)
                checkOutput("grant_exclusive", 2'b11, 2'b00);
            if ((bus.tx_gnt || bus.rx_gnt) && !prev_gnt) begin
                grant_cyc = cyc;
                mon_rx    = bus.rx_gnt;
                reads     = 0;
                starts    = 0;
                grant_count++;
            end
            if (bus.byte_rd) begin
                checkOutput("byte_addr_order", 32'(bus.byte_addr), 32'(reads));
                reads++;
            end
            if (bus.crc_start) begin
                logic [7:0] want;
                want = 8'h00;
                if (starts < NBYTES) want = mon_rx ? rx_buf[starts] : tx_buf[starts];
                checkOutput("crc_data_feed", 32'(bus.crc_data), 32'(want));
                starts++;
            end
            if (bus.tx_done || bus.rx_done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("done_both_high", 32'(bus.tx_done & bus.rx_done), 0);
                    checkOutput("done_owner", 32'(bus.rx_done), 32'(e.is_rx));
                    checkOutput("grant_owner", 32'(mon_rx), 32'(e.is_rx));
                    checkOutput("crc_out", 32'(bus.crc_out), 32'(e.crc));
                    checkOutput("crc_match", 32'(bus.crc_match), 32'(e.match));
                    checkOutput("latency", 32'(cyc - grant_cyc), 32'(LATENCY - 1));
                    checkOutput("read_count", 32'(reads), 32'(NBYTES));
                    checkOutput("start_count", 32'(starts), 32'(NBYTES + 1));
                end
            end
            prev_gnt = bus.tx_gnt || bus.rx_gnt;
        end
    end

    // Predicts the owners of the next blocks and raises the requests.
    task automatic applyStimulus(input bit tx, input bit rx, input int blocks);
        for (int i = 0; i < blocks; i++) begin
            exp_t e;
            e.is_rx   = (tx && rx) ? !last_rx_m : rx;
            last_rx_m = e.is_rx;
            e.crc     = refCrc(e.is_rx);
            e.match   = e.is_rx && (e.crc == bus.rx_expected);
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (tx) bus.tx_req = 1'b1;
        if (rx) bus.rx_req = 1'b1;
    endtask

    // Waits for n done pulses, with a bounded cycle budget. With drop_each
    // set, each owner drops its request on its own done pulse. Otherwise
    // both requests stay high until the last pulse.
    task automatic waitDones(input int n, input bit drop_each);
        int seen   = 0;
        int budget = n * (LATENCY + 100) + 2000;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.tx_done || bus.rx_done) begin
                seen++;
                if (drop_each || seen == n) begin
                    if (bus.tx_done) bus.tx_req = 1'b0;
                    if (bus.rx_done) bus.rx_req = 1'b0;
                end
            end
        end
        if (seen < n) checkOutput("done_timeout", 32'(seen), 32'(n));
        bus.tx_req = 1'b0;
        bus.rx_req = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_gnt"},    32'(bus.tx_gnt), 0);
        checkOutput({tag, "_rx_gnt"},    32'(bus.rx_gnt), 0);
        checkOutput({tag, "_byte_rd"},   32'(bus.byte_rd), 0);
        checkOutput({tag, "_byte_addr"}, 32'(bus.byte_addr), 0);
        checkOutput({tag, "_crc_clear"}, 32'(bus.crc_clear), 0);
        checkOutput({tag, "_crc_start"}, 32'(bus.crc_start), 0);
        checkOutput({tag, "_crc_data"},  32'(bus.crc_data), 0);
        checkOutput({tag, "_crc_out"},   32'(bus.crc_out), 0);
        checkOutput({tag, "_dones"},     32'({bus.tx_done, bus.rx_done}), 0);
        checkOutput({tag, "_crc_match"}, 32'(bus.crc_match), 0);
    endtask

    task automatic pulseReset(input string tag);
        @(negedge clk);
        bus.tx_req = 1'b0;
        bus.rx_req = 1'b0;
        reset      = 1'b1;
        #1;
        checkResetValues(tag);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        last_rx_m = 1'b1;
    endtask

    task automatic randomBuffers();
        for (int i = 0; i < NBYTES; i++) begin
            tx_buf[i] = 8'($urandom);
            rx_buf[i] = 8'($urandom);
        end
    endtask

    // Waits for the given number of crc_start pulses, with a bounded budget.
    task automatic waitStarts(input int n);
        int seen   = 0;
        int budget = LATENCY + 100;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.crc_start) seen++;
        end
        if (seen < n) checkOutput("start_timeout", 32'(seen), 32'(n));
    endtask

    initial begin
        bus.tx_req      = 1'b0;
        bus.rx_req      = 1'b0;
        bus.rx_expected = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            tx_buf[i] = 8'h00;
            rx_buf[i] = 8'(i);
        end
        repeat (2) @(negedge clk);
        checkResetValues("por");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // tx only, all-zero buffer: CRC 0x00, no match.
        applyStimulus(1'b1, 1'b0, 1);
        waitDones(1, 1'b1);

        // rx with bytes 0x00..0x1F: correct expectation, then one bit off.
        bus.rx_expected = refCrc(1'b1);
        applyStimulus(1'b0, 1'b1, 1);
        waitDones(1, 1'b1);
        bus.rx_expected = refCrc(1'b1) ^ 8'h01;
        applyStimulus(1'b0, 1'b1, 1);
        waitDones(1, 1'b1);

        // Simultaneous requests after reset, both held for four blocks.
        pulseReset("rst_tie");
        randomBuffers();
        bus.rx_expected = refCrc(1'b1);
        applyStimulus(1'b1, 1'b1, 4);
        waitDones(4, 1'b0);

        // Reset during WAIT_ENG of byte 10 abandons the block.
        randomBuffers();
        applyStimulus(1'b1, 1'b0, 1);
        waitStarts(11);
        repeat (5) @(negedge clk);
        exp_q.delete();
        pulseReset("rst_mid");
        begin
            int dones = 0;
            repeat (30) begin
                @(negedge clk);
                if (bus.tx_done || bus.rx_done) dones++;
            end
            checkOutput("no_done_after_abort", 32'(dones), 0);
        end
        bus.rx_expected = refCrc(1'b1);
        applyStimulus(1'b0, 1'b1, 1);
        waitDones(1, 1'b1);

        // tx drops its request at byte 5: the block still completes.
        begin
            int g0;
            randomBuffers();
            g0 = grant_count;
            applyStimulus(1'b1, 1'b0, 1);
            waitStarts(5);
            @(negedge clk);
            bus.tx_req = 1'b0;
            waitDones(1, 1'b1);
            repeat (30) @(negedge clk);
            checkOutput("single_grant", 32'(grant_count - g0), 1);
            checkOutput("grants_idle", 32'({bus.tx_gnt, bus.rx_gnt}), 0);
        end

        // rx arrives mid-block and is served after the tx block.
        randomBuffers();
        bus.rx_expected = refCrc(1'b1);
        applyStimulus(1'b1, 1'b0, 1);
        repeat ($urandom_range(100, 800)) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1);
        waitDones(2, 1'b1);

        // Randomized blocks: owner pattern, buffers and rx_expected.
        for (int r = 0; r < 4; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            randomBuffers();
            bus.rx_expected = refCrc(1'b1);
            if ($urandom_range(0, 1) == 1)
                bus.rx_expected = bus.rx_expected ^ 8'(1 << $urandom_range(0, 7));
            repeat ($urandom_range(1, 20)) @(negedge clk);
            if (mode == 0) begin
                applyStimulus(1'b1, 1'b0, 1);
                waitDones(1, 1'b1);
            end else if (mode == 1) begin
                applyStimulus(1'b0, 1'b1, 1);
                waitDones(1, 1'b1);
            end else begin
                applyStimulus(1'b1, 1'b1, 2);
                waitDones(2, 1'b1);
            end
        end

        repeat (10) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
